// File: rtl/ifu_fetch_pkg.sv
// ifu_fetch_pkg: fetch-stage FSM states, next-PC select codes and decoder-shared opcodes
package ifu_fetch_pkg;
  typedef logic [1:0] state_t;
  localparam state_t S_IDLE  = 2'd0;
  localparam state_t S_FETCH = 2'd1;
  localparam state_t S_HOLD  = 2'd2;
  localparam state_t S_ERR   = 2'd3;
  localparam logic [1:0] NPC_SEQ = 2'b00;
  localparam logic [1:0] NPC_BR  = 2'b01;
  localparam logic [1:0] NPC_J   = 2'b10;
  localparam logic [1:0] NPC_JR  = 2'b11;
  localparam logic [31:0] RESET_PC_DEF = 32'h0000_3000;
  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] FN_JR    = 6'h08;
  localparam logic [5:0] FN_JALR  = 6'h09;
  function automatic logic [31:0] br_offset(input logic [15:0] imm);
    return {{14{imm[15]}}, imm, 2'b00};
  endfunction
endpackage

// File: rtl/ifu_fetch_npc_calc.sv
// npc_calc: combinational next-PC selection for sequential, branch, jump and register-jump flow
module npc_calc
  import ifu_fetch_pkg::*;
(
  input  logic [31:0] pc,
  input  logic [25:0] target,
  input  logic [31:0] rs_val,
  input  logic [1:0]  npc_sel,
  input  logic        br_cond,
  output logic [31:0] pc_plus4,
  output logic [31:0] npc,
  output logic        misaligned
);
  assign pc_plus4 = pc + 32'd4;
  always_comb
    npc = npc_sel == NPC_JR ? rs_val :
          npc_sel == NPC_J ? {pc_plus4[31:28], target, 2'b00} :
          (npc_sel == NPC_BR && br_cond) ? pc_plus4 + br_offset(target[15:0]) :
          pc_plus4;
  assign misaligned = |npc[1:0];
endmodule

// File: rtl/ifu_fetch.sv
// ifu_fetch: instruction fetch unit holding one instruction for decode and steering the PC
module ifu_fetch
  import ifu_fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEF,
  parameter int          IMEM_AW  = 32
) (
  input  logic               clk,
  input  logic               rst,
  output logic               imem_req,
  output logic [IMEM_AW-1:0] imem_addr,
  input  logic               imem_ready,
  input  logic [31:0]        imem_rdata,
  output logic [31:0]        instr,
  output logic [5:0]         op,
  output logic [4:0]         rt,
  output logic [5:0]         funct,
  output logic               instr_valid,
  input  logic               instr_accept,
  input  logic [1:0]         npc_sel,
  input  logic               br_cond,
  input  logic [31:0]        rs_val,
  output logic [31:0]        pc,
  output logic [31:0]        pc_plus4,
  output logic               addr_err
);
  state_t      state;
  logic [31:0] npc;
  logic        npc_bad;
  npc_calc u_npc (
    .pc         (pc),
    .target     (instr[25:0]),
    .rs_val     (rs_val),
    .npc_sel    (npc_sel),
    .br_cond    (br_cond),
    .pc_plus4   (pc_plus4),
    .npc        (npc),
    .misaligned (npc_bad)
  );
  assign imem_req    = state == S_FETCH;
  assign imem_addr   = IMEM_AW'(pc);
  assign instr_valid = state == S_HOLD;
  assign op          = instr[31:26];
  assign rt          = instr[20:16];
  assign funct       = instr[5:0];
  // a misaligned target freezes pc at the offending instruction until reset
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state    <= S_IDLE;
      pc       <= RESET_PC;
      instr    <= '0;
      addr_err <= 1'b0;
    end else if (state == S_IDLE) begin
      state <= S_FETCH;
    end else if (state == S_FETCH && imem_ready) begin
      instr <= imem_rdata;
      state <= S_HOLD;
    end else if (state == S_HOLD && instr_accept) begin
      if (npc_bad) begin
        addr_err <= 1'b1;
        state    <= S_ERR;
      end else begin
        pc    <= npc;
        state <= S_FETCH;
      end
    end
endmodule

// File: tb/tb_ifu_fetch.sv
// tb_ifu_fetch: randomized scoreboard bench for ifu_fetch against a behavioural fetch model
module tb_ifu_fetch;
  typedef struct { logic err; logic [31:0] a; } exp_t;
  typedef struct { logic [1:0] sel; logic c; logic [31:0] rs; } choice_t;
  logic        clk = 0, rst = 1;
  logic        imem_req, imem_ready = 0, instr_valid, instr_accept = 0, br_cond = 0, addr_err;
  logic [31:0] imem_addr, imem_rdata = 0, instr, rs_val = 0, pc, pc_plus4;
  logic [5:0]  op, funct;
  logic [4:0]  rt;
  logic [1:0]  npc_sel = 0;
  exp_t        addr_q[$];
  choice_t     plan[$];
  int          lat_q[$], lat_plan[$];
  logic [31:0] fetch_log[$], exp_log[$];
  logic [31:0] mem [logic [31:0]];
  logic [31:0] model_pc = 32'h0000_3000;
  bit          rand_en = 0;
  int          n_checks = 0, n_fail = 0;

  ifu_fetch dut (
    .clk(clk), .rst(rst), .imem_req(imem_req), .imem_addr(imem_addr), .imem_ready(imem_ready),
    .imem_rdata(imem_rdata), .instr(instr), .op(op), .rt(rt), .funct(funct),
    .instr_valid(instr_valid), .instr_accept(instr_accept), .npc_sel(npc_sel), .br_cond(br_cond),
    .rs_val(rs_val), .pc(pc), .pc_plus4(pc_plus4), .addr_err(addr_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp_v);
    n_checks++;
    if (act !== exp_v) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", nm, act, exp_v, $time);
    end
  endtask

  function automatic logic [31:0] mem_get(input logic [31:0] a);
    if (!mem.exists(a)) mem[a] = $urandom;
    return mem[a];
  endfunction

  // Reference next-PC, straight from the architectural rules
  function automatic logic [31:0] ref_next(input logic [31:0] p, input logic [31:0] ins,
                                           input logic [31:0] rs, input logic [1:0] s, input logic c);
    logic [31:0] seq;
    seq = p + 32'd4;
    if (s == 2'd3) return rs;
    if (s == 2'd2) return (seq & 32'hF000_0000) | ((ins & 32'h03FF_FFFF) * 32'd4);
    if (s == 2'd1 && c) return 32'(int'(seq) + int'($signed(ins[15:0])) * 4);
    return seq;
  endfunction

  task automatic do_reset();
    @(posedge clk); #1;
    rst = 1;
    rand_en = 0;
    addr_q.delete(); lat_q.delete(); lat_plan.delete(); plan.delete(); fetch_log.delete();
    model_pc = 32'h0000_3000;
    @(negedge clk);
    chk("rst_req", imem_req, 0);
    chk("rst_valid", instr_valid, 0);
    chk("rst_pc", pc, 32'h0000_3000);
    chk("rst_instr", instr, 0);
    chk("rst_addr_err", addr_err, 0);
    @(posedge clk); #1;
    addr_q.push_back(exp_t'{1'b0, 32'h0000_3000});
    rst = 0;
    @(negedge clk);
    chk("idle_one_cycle", imem_req, 0);
  endtask

  task automatic check_log();
    chk("fetch_count", fetch_log.size(), exp_log.size());
    foreach (exp_log[i]) chk("fetch_seq", i < fetch_log.size() ? fetch_log[i] : 32'hxxxx_xxxx, exp_log[i]);
  endtask

  // memory responder: per-request latency, junk ready/data whenever no request is pending
  initial begin
    int left;
    bit busy;
    left = 0;
    busy = 0;
    forever begin
      @(posedge clk); #3;
      if (rst) begin
        busy = 0; imem_ready = 1; imem_rdata = $urandom;
      end else if (imem_req) begin
        if (!busy) begin
          busy = 1;
          left = lat_plan.size() > 0 ? lat_plan.pop_front() : $urandom_range(0, 3);
          lat_q.push_back(left);
        end
        if (left == 0) begin
          imem_ready = 1; imem_rdata = mem_get(imem_addr); busy = 0;
        end else begin
          imem_ready = 0; imem_rdata = $urandom; left--;
        end
      end else begin
        imem_ready = $urandom_range(0, 3) != 0; imem_rdata = $urandom;
      end
    end
  end

  // decode-side driver: chooses next-PC controls and records the expected next fetch
  initial begin
    choice_t ch;
    logic [31:0] nx;
    forever begin
      @(posedge clk); #2;
      instr_accept = 0; npc_sel = 2'($urandom); br_cond = 1'($urandom); rs_val = $urandom;
      if (!rst) begin
        if (instr_valid && (plan.size() > 0 || (rand_en && $urandom_range(0, 2) == 0))) begin
          if (plan.size() > 0) ch = plan.pop_front();
          else begin
            ch.sel = 2'($urandom);
            ch.c   = 1'($urandom);
            ch.rs  = $urandom_range(0, 7) == 0 ? $urandom : ($urandom & 32'hFFFF_FFFC);
          end
          npc_sel = ch.sel; br_cond = ch.c; rs_val = ch.rs; instr_accept = 1;
          nx = ref_next(model_pc, mem_get(model_pc), ch.rs, ch.sel, ch.c);
          addr_q.push_back(exp_t'{nx[1:0] != 2'b00, nx});
          if (nx[1:0] == 2'b00) model_pc = nx;
        end else if (!instr_valid) instr_accept = rand_en && 1'($urandom);
      end
    end
  end

  // monitor: pops expectations as the DUT starts fetches, presents instructions or errors out
  initial begin
    logic prev_req, prev_valid, prev_hs, in_err;
    logic [31:0] cur, last_instr, ei;
    int req_cycles, lat;
    exp_t e;
    prev_req = 0; prev_valid = 0; prev_hs = 0; in_err = 0;
    cur = 0; last_instr = 0; req_cycles = 0;
    forever begin
      @(negedge clk);
      if (rst) begin
        prev_req = 0; prev_valid = 0; prev_hs = 0; in_err = 0;
        cur = 0; last_instr = 0; req_cycles = 0;
      end else begin
        if (prev_hs) chk("valid_after_ready", instr_valid, 1);
        if (in_err) begin
          chk("err_no_req", imem_req, 0);
          chk("err_no_valid", instr_valid, 0);
          chk("err_flag", addr_err, 1);
        end else begin
          if (imem_req && !prev_req) begin
            if (addr_q.size() == 0) begin
              n_checks++; n_fail++;
              $display("FAIL unexpected_fetch: got addr %h, expected no fetch", imem_addr);
            end else begin
              e = addr_q.pop_front();
              chk("fetch_not_err", e.err, 0);
              chk("fetch_addr", imem_addr, e.a);
              cur = e.a;
            end
            fetch_log.push_back(imem_addr);
            req_cycles = 0;
          end
          if (prev_valid && !instr_valid && !imem_req) begin
            if (addr_q.size() == 0) begin
              n_checks++; n_fail++;
              $display("FAIL unexpected_exit: got state exit with addr_err %b, expected hold", addr_err);
            end else begin
              e = addr_q.pop_front();
              chk("err_expected", e.err, 1);
              chk("err_flag_set", addr_err, 1);
              in_err = 1;
            end
          end
          if (imem_req) begin
            chk("addr_stable", imem_addr, cur);
            chk("instr_held_in_fetch", instr, last_instr);
            req_cycles++;
          end
          if (instr_valid) begin
            ei = mem_get(cur);
            if (!prev_valid) begin
              lat = lat_q.size() > 0 ? lat_q.pop_front() : -1;
              chk("fetch_latency", req_cycles, lat + 1);
            end
            chk("pc", pc, cur);
            chk("instr", instr, ei);
            chk("pc_plus4", pc_plus4, cur + 32'd4);
            chk("op", op, ei[31:26]);
            chk("rt", rt, ei[20:16]);
            chk("funct", funct, ei[5:0]);
            chk("hold_no_req", imem_req, 0);
            chk("addr_err_clear", addr_err, 0);
            last_instr = ei;
          end
        end
        prev_req = imem_req; prev_valid = instr_valid; prev_hs = imem_req && imem_ready;
      end
    end
  end

  initial begin
    bit seen;
    // three sequential accepts, third fetch waits three cycles
    do_reset();
    lat_plan = {0, 0, 3};
    repeat (3) plan.push_back(choice_t'{2'd0, 1'b0, 32'h0});
    repeat (30) @(posedge clk);
    @(negedge clk);
    exp_log = {32'h3000, 32'h3004, 32'h3008, 32'h300C};
    check_log();
    chk("drained_seq", addr_q.size(), 0);
    // jump, taken branch, sequential, untaken branch, then a misaligned register jump
    mem[32'h3000] = {6'h02, 26'h000_0C04};
    mem[32'h3010] = {6'h04, 5'd1, 5'd2, 16'hFFFE};
    do_reset();
    plan.push_back(choice_t'{2'd2, 1'b0, 32'h0});
    plan.push_back(choice_t'{2'd1, 1'b1, 32'h0});
    plan.push_back(choice_t'{2'd0, 1'b0, 32'h0});
    plan.push_back(choice_t'{2'd1, 1'b0, 32'h0});
    plan.push_back(choice_t'{2'd3, 1'b0, 32'h0000_3002});
    repeat (50) @(posedge clk);
    @(negedge clk);
    exp_log = {32'h3000, 32'h3010, 32'h300C, 32'h3010, 32'h3014};
    check_log();
    chk("err_addr_err", addr_err, 1);
    chk("err_pc_frozen", pc, 32'h3014);
    chk("err_valid_low", instr_valid, 0);
    chk("err_req_low", imem_req, 0);
    chk("drained_err", addr_q.size(), 0);
    // reset in the middle of a memory wait
    do_reset();
    lat_plan = {3};
    seen = 0;
    for (int i = 0; i < 10 && !seen; i++) begin
      @(negedge clk);
      seen = imem_req;
    end
    chk("mid_fetch_req_seen", seen, 1);
    do_reset();
    repeat (15) @(posedge clk);
    @(negedge clk);
    exp_log = {32'h3000};
    check_log();
    chk("post_rst_valid", instr_valid, 1);
    chk("post_rst_instr", instr, mem_get(32'h3000));
    // randomized epochs
    for (int ep = 0; ep < 4; ep++) begin
      do_reset();
      rand_en = 1;
      repeat (400) @(posedge clk);
      rand_en = 0;
      repeat (12) @(posedge clk);
      @(negedge clk);
      chk("drained_rand", addr_q.size(), 0);
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/ifu_fetch.md
IFU_FETCH -- requirements
Module: ifu_fetch

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_3000, sets the first fetch address after reset.
REQ-002 Parameter IMEM_AW, default 32, sets the instruction address width.
REQ-003 clk  in  1  single clock; all state updates on its rising edge.
REQ-004 rst  in  1  reset, asynchronous, active-high.
REQ-005 imem_req  out  1  fetch request to instruction memory.
REQ-006 imem_addr  out  IMEM_AW  byte address of the requested word.
REQ-007 imem_ready  in  1  memory returns imem_rdata this cycle.
REQ-008 imem_rdata  in  32  fetched instruction word.
REQ-009 instr  out  32  held instruction for the decode stage.
REQ-010 op / rt / funct  out  6 / 5 / 6  fields instr[31:26], instr[20:16], instr[5:0] for the ALU-op decoder.
REQ-011 instr_valid  out  1  instr is valid.
REQ-012 instr_accept  in  1  decode/execute consumes instr this cycle.
REQ-013 npc_sel  in  2  next-PC select: 00 seq, 01 branch, 10 jump, 11 register jump.
REQ-014 br_cond  in  1  branch condition, i.e. the ALU compare result bit.
REQ-015 rs_val  in  32  register target for jr/jalr.
REQ-016 pc  out  32  address of the held instruction.
REQ-017 pc_plus4  out  32  link value for jal/jalr.
REQ-018 addr_err  out  1  sticky misaligned-target flag.

Function
REQ-019 FSM states are IDLE, FETCH, HOLD and ERR.
REQ-020 IDLE lasts exactly one cycle after reset release, then goes to FETCH.
REQ-021 FETCH: imem_req=1 and imem_addr=pc; both stay stable until imem_ready.
REQ-022 FETCH: on imem_ready, instr <= imem_rdata, then go to HOLD; fetch latency is 1 cycle plus the memory wait cycles.
REQ-023 HOLD: instr_valid=1 and imem_req=0; imem_ready is ignored in IDLE and HOLD.
REQ-024 HOLD without instr_accept: instr, pc and instr_valid hold their values.
REQ-025 HOLD with instr_accept: pc <= next_pc, computed from npc_sel, br_cond and rs_val sampled that cycle, then go to FETCH.
REQ-026 next_pc for seq, or for branch with br_cond=0: pc+4.
REQ-027 next_pc for branch with br_cond=1: pc+4 + (sign-extended instr[15:0] << 2), modulo 2^32.
REQ-028 next_pc for jump: {pc_plus4[31:28], instr[25:0], 2'b00}.
REQ-029 next_pc for register jump: rs_val.
REQ-030 If the selected next_pc has bits [1:0] != 0: pc is not updated, addr_err=1, go to ERR.
REQ-031 ERR: no requests, instr_valid=0; it is left only by reset.
REQ-032 pc_plus4 = pc+4, which wraps 32'hFFFF_FFFC to 0.
REQ-033 op, rt and funct are derived combinationally from the registered instr.
REQ-034 instr_accept outside HOLD is ignored.

Reset
REQ-035 rst asserted in any state, including mid-fetch, immediately forces the following: state=IDLE; pc=RESET_PC; instr=0; instr_valid=0; imem_req=0; addr_err=0.
REQ-036 An outstanding memory response that arrives during or after reset is discarded.

Structure
REQ-037 A shared package holds the FSM state type, the npc_sel codes, RESET_PC, and opcode/funct constants common with the decoder.
REQ-038 The next-PC arithmetic is a combinational sub-module, npc_calc, instantiated once.

Verification
REQ-039 Reset then three sequential accepts with imem_ready=1 -> addresses 3000, 3004, 3008 are requested; each instr_valid follows 1 cycle after imem_ready.
REQ-040 Memory wait of 3 cycles -> imem_addr is held constant for 4 cycles; instr updates only on the ready cycle.
REQ-041 beq at pc 3010 with imm 16'hFFFE, br_cond=1 -> next fetch is 300C; with br_cond=0 -> next fetch is 3014.
REQ-042 jump with instr[25:0]=26'h0000C04 at pc 3000 -> next fetch is 0000_3010.
REQ-043 Register jump with rs_val=32'h0000_3002 -> addr_err=1, state ERR, no further imem_req until rst.
REQ-044 rst pulsed during a FETCH wait, with imem_ready arriving 1 cycle later -> response is ignored, instr_valid=0, and the first post-reset request goes to 3000.
